aes_inv_cipher_top: RTL and testbench
=====================================

Name: aes_inv_cipher_top

Overview:
Iterative AES-128 decryption core. It is the receive-side counterpart of aes_cipher_top and recovers plaintext from ciphertext produced by the encryption path.
- A key-load phase expands the cipher key once into an internal 11-entry round-key store.
- Each block is then decrypted in 10 round iterations using the stored keys in reverse order.
- It sits beside aes_cipher_top and is reused by existing aes_input_buffer-style wrappers. The ld/done/text_in/text_out handshake has the same meaning as on the cipher.

Parameters:
none (AES-128 only; Nr = 10 fixed)

Ports:
clk       in   1    system clock; all state updates on rising edge
rst       in   1    synchronous, active-high reset
kld       in   1    key-load strobe; key sampled on the edge where kld=1 is accepted
key       in   128  cipher key; key[127:120] = key byte 0 (FIPS-197 order)
key_ready out  1    round-key store valid; ld is accepted only when key_ready=1 and busy=0
ld        in   1    block-load strobe; text_in sampled on the accepted edge
text_in   in   128  ciphertext; text_in[127:120] = state byte s(0,0), column-major
busy      out  1    key expansion or decryption in progress
done      out  1    one-cycle pulse; text_out valid
text_out  out  128  plaintext; holds its value until the next done

Behaviour:
- Reset (rst=1 sampled at an edge):
  - key_ready=0, busy=0, done=0, text_out=0.
  - FSM goes to IDLE; round counter = 0; round-key contents are don't-care.
  - Reset mid-operation aborts it; no done is produced.
- FSM states: IDLE, KEXP, DEC.
- IDLE, kld=1:
  - rk[0] <= key.
  - key_ready <= 0, busy <= 1, cnt <= 1, go to KEXP.
  - kld has priority over a simultaneous ld; that ld is dropped.
- KEXP, one round key per cycle:
  - rk[cnt] = standard AES-128 expansion of rk[cnt-1], i.e. RotWord/SubWord with rcon[cnt] = 01,02,04,08,10,20,40,80,1b,36 on w3, then the xor chain.
  - Uses the existing forward S-box. After rk[10] is written: key_ready <= 1, busy <= 0, go to IDLE.
  - key_ready therefore rises 10 edges after the kld edge.
- IDLE, ld=1, key_ready=1, kld=0:
  - state <= text_in ^ rk[10].
  - busy <= 1, cnt <= 9, go to DEC.
- ld with key_ready=0 or busy=1 is ignored (no error flag).
- kld while busy=1 is ignored.
- DEC, cnt = 9..1, one round per cycle:
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[cnt]); cnt decrements.
- DEC, cnt = 0 (final round):
  - text_out <= InvSubBytes(InvShiftRows(state)) ^ rk[0] (no InvMixColumns).
  - done <= 1 for exactly one cycle; busy <= 0; go to IDLE.
- Latency:
  - done is high in the cycle after the 10th edge following the accepted ld edge.
  - A new ld may be accepted in the same cycle that done is high (back-to-back: one block per 11 cycles).
- The round-key store persists across any number of blocks until the next kld or reset.
- InvMixColumns coefficients are 0e,0b,0d,09 over GF(2^8) with reduction polynomial 0x11b.
- InvSubBytes uses the existing inverse S-box module: 16 instances for state and 4 forward S-boxes for expansion.
- text_in is only sampled at the accepted ld edge; changes afterwards have no effect.

Test Plan:
1. Reset, then kld with key 000102030405060708090a0b0c0d0e0f -> key_ready=1 exactly 10 cycles later. Then ld with text_in 69c4e0d86a7b0430d8cdb78070b4c55a -> done one cycle after 10 edges, text_out = 00112233445566778899aabbccddeeff.
2. kld with key 2b7e151628aed2a6abf7158809cf4f3c, ld 3925841d02dc09fbdc118597196a0b32 -> text_out 3243f6a8885a308d313198a2e0370734. Then ld 3925841d… again, asserted in the done cycle -> identical result 11 cycles later.
3. kld with key all-zero, ld 66e94bd4ef8a2c3b884cfa59ca342b2e -> text_out all-zero. Also loop the output of aes_cipher_top into this block for 100 random key/text pairs -> plaintext matches.
4. ld before any kld, ld during KEXP, and ld/kld during DEC -> each ignored. No extra done; the in-flight result matches test 1.
5. Simultaneous kld and ld in IDLE -> expansion starts, ld dropped, done stays 0.
6. rst asserted at cnt=5 of DEC -> next cycle busy=0, key_ready=0, text_out=0, and no done. A fresh kld/ld then reproduces test 1.

Source files
------------

// File: rtl/aes_inv_cipher_top_if.sv
// ---------------------------------------------------------------------------
// aes_inv_cipher_top_if
//   This interface bundles the key-load, block-load and result signals of the
//   iterative AES-128 decryption core.
//
//   master : drives kld/key/ld/text_in and observes key_ready/busy/done/text_out
//   slave  : the decryption core itself
//
//   kld       key-load strobe
//   key       128-bit cipher key, byte 0 in key[127:120]
//   key_ready round-key store holds a complete expanded key
//   ld        block-load strobe
//   text_in   128-bit ciphertext, s(0,0) in text_in[127:120], column-major
//   busy      key expansion or decryption in progress
//   done      one-cycle pulse when text_out is updated
//   text_out  128-bit plaintext, held until the next done
// ---------------------------------------------------------------------------
interface aes_inv_cipher_top_if;
  logic         kld;
  logic [127:0] key;
  logic         key_ready;
  logic         ld;
  logic [127:0] text_in;
  logic         busy;
  logic         done;
  logic [127:0] text_out;

  modport master (
    output kld, key, ld, text_in,
    input  key_ready, busy, done, text_out
  );

  modport slave (
    input  kld, key, ld, text_in,
    output key_ready, busy, done, text_out
  );
endinterface

// File: rtl/aes_inv_cipher_top.sv
// ---------------------------------------------------------------------------
// aes_inv_cipher_top
//   This is an iterative AES-128 decryption core. A key load expands the
//   cipher key into an 11-entry round-key store, producing one round key per
//   cycle. Each block is then decrypted in ten round iterations, one per
//   cycle, walking the stored round keys from rk[10] down to rk[0].
//
//   Ports:
//     clk   system clock, all state changes on the rising edge
//     rst   synchronous active-high reset
//     bus   aes_inv_cipher_top_if.slave
//             kld/key          -> key expansion request
//             ld/text_in       -> block decryption request
//             key_ready/busy   -> status
//             done/text_out    -> result pulse and held plaintext
//
//   Byte order: byte i of a 128-bit word lives in bits [127-8*i -: 8], and
//   state byte s(r,c) is byte 4*c+r.
// ---------------------------------------------------------------------------
module aes_inv_cipher_top (
  input  logic                 clk,
  input  logic                 rst,
  aes_inv_cipher_top_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] KEXP = 2'd1;
  localparam logic [1:0] DEC  = 2'd2;

  logic [1:0]   fsm;
  logic [3:0]   cnt;
  logic [127:0] rk [0:10];
  logic [127:0] rk_last;
  logic [127:0] st;
  logic         key_ready_q;
  logic         busy_q;
  logic         done_q;
  logic [127:0] text_out_q;

  // --------------------------------------------------------------------------
  // GF(2^8) helpers, reduction polynomial 0x11b
  // --------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 with a fixed square-and-multiply chain;
  // zero maps to zero, which is exactly what the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p2, p3, p6, p7, p14, p15, p30, p60, p120, p127;
    p2   = gf_mul(a, a);
    p3   = gf_mul(p2, a);
    p6   = gf_mul(p3, p3);
    p7   = gf_mul(p6, a);
    p14  = gf_mul(p7, p7);
    p15  = gf_mul(p14, a);
    p30  = gf_mul(p15, p15);
    p60  = gf_mul(p30, p30);
    p120 = gf_mul(p60, p60);
    p127 = gf_mul(p120, p7);
    return gf_mul(p127, p127);
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction
  function automatic logic [7:0] rotl2(input logic [7:0] b);
    return {b[5:0], b[7:6]};
  endfunction
  function automatic logic [7:0] rotl3(input logic [7:0] b);
    return {b[4:0], b[7:5]};
  endfunction
  function automatic logic [7:0] rotl4(input logic [7:0] b);
    return {b[3:0], b[7:4]};
  endfunction
  function automatic logic [7:0] rotl6(input logic [7:0] b);
    return {b[1:0], b[7:2]};
  endfunction

  // The forward S-box is the field inverse followed by the affine transform.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] inv;
    inv = gf_inv(a);
    return inv ^ rotl1(inv) ^ rotl2(inv) ^ rotl3(inv) ^ rotl4(inv) ^ 8'h63;
  endfunction

  // The inverse S-box undoes the affine transform first, then inverts.
  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    return gf_inv(rotl1(a) ^ rotl3(a) ^ rotl6(a) ^ 8'h05);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Request decode. Both strobes are only looked at in IDLE, so anything that
  // arrives during expansion or decryption is dropped. A key load wins over a
  // simultaneous block load.
  // --------------------------------------------------------------------------
  logic start_key;
  logic start_blk;

  assign start_key = (fsm == IDLE) && bus.kld;
  assign start_blk = (fsm == IDLE) && !bus.kld && bus.ld && key_ready_q;

  // --------------------------------------------------------------------------
  // Key expansion step. rk_last always holds the most recently produced round
  // key, so each cycle only needs the previous key and the round constant for
  // the index being written.
  // --------------------------------------------------------------------------
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  w0, w1, w2, w3;
  logic [127:0] rk_next;

  always_comb begin
    rot_word = {rk_last[23:0], rk_last[31:24]};
    sub_word = {sbox_fwd(rot_word[31:24]), sbox_fwd(rot_word[23:16]),
                sbox_fwd(rot_word[15:8]),  sbox_fwd(rot_word[7:0])};
    w0       = rk_last[127:96] ^ sub_word ^ {rcon(cnt), 24'h000000};
    w1       = rk_last[95:64]  ^ w0;
    w2       = rk_last[63:32]  ^ w1;
    w3       = rk_last[31:0]   ^ w2;
    rk_next  = {w0, w1, w2, w3};
  end

  // --------------------------------------------------------------------------
  // Decryption round datapath. InvShiftRows moves s(r,c) from column c-r,
  // then every byte passes through the inverse S-box and the round key
  // selected by cnt is added. The last round skips InvMixColumns.
  // --------------------------------------------------------------------------
  logic [127:0] isr;
  logic [127:0] isb;
  logic [127:0] ark;
  logic [127:0] imc;
  logic [127:0] rk_cur;

  assign rk_cur = rk[cnt];

  always_comb begin
    isr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        isr[127-8*(4*c+r) -: 8] = st[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    isb = '0;
    for (int i = 0; i < 16; i++) begin
      isb[127-8*i -: 8] = sbox_inv(isr[127-8*i -: 8]);
    end
    ark = isb ^ rk_cur;
    imc = '0;
    for (int c = 0; c < 4; c++) begin
      imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM. cnt counts up 1..10 while the key is expanded and down 9..0
  // while a block is decrypted; the step with cnt==0 is the final round and
  // raises done for a single cycle. Reset clears every visible output and
  // abandons whatever was in progress.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm         <= IDLE;
      cnt         <= 4'd0;
      key_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      text_out_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start_key) begin
            key_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            cnt         <= 4'd1;
            fsm         <= KEXP;
          end else if (start_blk) begin
            busy_q <= 1'b1;
            cnt    <= 4'd9;
            fsm    <= DEC;
          end
        end
        KEXP: begin
          if (cnt == 4'd10) begin
            key_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            cnt         <= 4'd0;
            fsm         <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DEC: begin
          if (cnt == 4'd0) begin
            text_out_q <= ark;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            fsm        <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Round-key store and round state. These carry no reset because their
  // contents are only meaningful once key_ready or a decryption sequence has
  // been started from a clean FSM.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (start_key) begin
      rk[0]   <= bus.key;
      rk_last <= bus.key;
    end else if (fsm == KEXP) begin
      rk[cnt] <= rk_next;
      rk_last <= rk_next;
    end

    if (start_blk) begin
      st <= bus.text_in ^ rk[10];
    end else if ((fsm == DEC) && (cnt != 4'd0)) begin
      st <= imc;
    end
  end

  assign bus.key_ready = key_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.text_out  = text_out_q;

endmodule

// File: tb/tb_aes_inv_cipher_top.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_cipher_top
//   Self-checking bench for aes_inv_cipher_top. A byte-level AES-128 model
//   (table-built S-box, FIPS-197 cipher and inverse cipher) supplies the
//   expected plaintexts; known-answer vectors are checked as constants.
// ---------------------------------------------------------------------------
module tb_aes_inv_cipher_top;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT3  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;
  int   done_seen  = 0;

  logic [7:0]  sbox_t  [256];
  logic [7:0]  isbox_t [256];
  logic [31:0] w_m     [44];

  always #5 clk = ~clk;

  aes_inv_cipher_top_if bus ();

  aes_inv_cipher_top dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Count done pulses on the rising edge, before the DUT updates them.
  always @(posedge clk) begin
    if (bus.done === 1'b1) done_seen++;
  end

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) r = r ^ a;
      a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return r;
  endfunction

  // Walk the powers of the generator 3 and its inverse together to fill the
  // S-box, then invert the table for the inverse S-box.
  function automatic void buildTables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = i[7:0];
  endfunction

  function automatic void keyExpand(input logic [127:0] k);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w_m[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w_m[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t  = t ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w_m[i] = w_m[i-4] ^ t;
    end
  endfunction

  function automatic logic [7:0] rkb(input int rnd, input int i);
    logic [31:0] w;
    w = w_m[4*rnd + i/4];
    return w[31-8*(i%4) -: 8];
  endfunction

  function automatic logic [127:0] modelEncrypt(input logic [127:0] pt);
    logic [7:0]   s   [16];
    logic [7:0]   tmp [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rkb(0, i);
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) tmp[i] = sbox_t[s[i]];
      for (int i = 0; i < 16; i++) s[i] = tmp[4*(((i/4) + (i%4)) % 4) + (i%4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rkb(rnd, i);
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] modelDecrypt(input logic [127:0] ct);
    logic [7:0]   s   [16];
    logic [7:0]   tmp [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ rkb(10, i);
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int i = 0; i < 16; i++) tmp[4*(((i/4) + (i%4)) % 4) + (i%4)] = s[i];
      for (int i = 0; i < 16; i++) s[i] = isbox_t[tmp[i]] ^ rkb(rnd, i);
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
          s[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
          s[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
          s[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus and checking helpers
  // --------------------------------------------------------------------------
  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
    end
  endtask

  // Called at a falling edge: holds the strobes for exactly one rising edge,
  // then scrambles the data buses so late sampling would show up.
  task automatic applyStimulus(input logic k, input logic [127:0] kv,
                               input logic l, input logic [127:0] tv);
    bus.kld     = k;
    bus.key     = kv;
    bus.ld      = l;
    bus.text_in = tv;
    @(negedge clk);
    bus.kld     = 1'b0;
    bus.ld      = 1'b0;
    bus.key     = rand128();
    bus.text_in = rand128();
  endtask

  task automatic waitKeyReady(output int cycles);
    cycles = 0;
    while (bus.key_ready !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int           cyc;
    int           d0;
    logic [127:0] k;
    logic [127:0] p;
    logic [127:0] c;

    buildTables();
    bus.kld     = 1'b0;
    bus.ld      = 1'b0;
    bus.key     = '0;
    bus.text_in = '0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("rst_key_ready", 128'(bus.key_ready), 128'd0);
    checkOutput("rst_busy",      128'(bus.busy),      128'd0);
    checkOutput("rst_done",      128'(bus.done),      128'd0);
    checkOutput("rst_text_out",  bus.text_out,        128'd0);

    // ld before any key has been loaded
    applyStimulus(1'b0, '0, 1'b1, CT1);
    repeat (12) @(negedge clk);
    checkOutput("nokey_busy",  128'(bus.busy), 128'd0);
    checkOutput("nokey_dones", 128'(done_seen), 128'd0);

    // key load with a stray ld in the middle of expansion
    applyStimulus(1'b1, KEY1, 1'b0, '0);
    checkOutput("kexp_busy",      128'(bus.busy),      128'd1);
    checkOutput("kexp_key_ready", 128'(bus.key_ready), 128'd0);
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, '0, 1'b1, CT1);
    waitKeyReady(cyc);
    checkOutput("kexp_latency", 128'(4 + cyc), 128'd10);
    repeat (12) @(negedge clk);
    checkOutput("kexp_ld_busy",  128'(bus.busy), 128'd0);
    checkOutput("kexp_ld_dones", 128'(done_seen), 128'd0);

    // test 1 known answer
    keyExpand(KEY1);
    applyStimulus(1'b0, '0, 1'b1, CT1);
    waitDone(cyc);
    checkOutput("t1_latency", 128'(cyc), 128'd10);
    checkOutput("t1_text",    bus.text_out, PT1);
    checkOutput("t1_model",   bus.text_out, modelDecrypt(CT1));
    @(negedge clk);
    checkOutput("t1_done_pulse", 128'(bus.done), 128'd0);
    checkOutput("t1_text_hold",  bus.text_out,   PT1);

    // kld and ld while a block is in flight are both ignored
    applyStimulus(1'b0, '0, 1'b1, CT1);
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, KEY2, 1'b1, CT2);
    waitDone(cyc);
    checkOutput("dec_ignore_latency", 128'(4 + cyc), 128'd10);
    checkOutput("dec_ignore_text",    bus.text_out, PT1);
    repeat (12) @(negedge clk);
    checkOutput("dec_ignore_busy",      128'(bus.busy),      128'd0);
    checkOutput("dec_ignore_key_ready", 128'(bus.key_ready), 128'd1);
    checkOutput("dec_ignore_dones",     128'(done_seen),     128'd2);

    // test 2 known answer plus back-to-back ld in the done cycle
    applyStimulus(1'b1, KEY2, 1'b0, '0);
    waitKeyReady(cyc);
    checkOutput("t2_kready_latency", 128'(cyc), 128'd10);
    applyStimulus(1'b0, '0, 1'b1, CT2);
    waitDone(cyc);
    checkOutput("t2_text", bus.text_out, PT2);
    applyStimulus(1'b0, '0, 1'b1, CT2);
    waitDone(cyc);
    checkOutput("t2_b2b_period", 128'(1 + cyc), 128'd11);
    checkOutput("t2_b2b_text",   bus.text_out, PT2);

    // test 3 known answer with the all-zero key
    applyStimulus(1'b1, 128'd0, 1'b0, '0);
    waitKeyReady(cyc);
    applyStimulus(1'b0, '0, 1'b1, CT3);
    waitDone(cyc);
    checkOutput("t3_text", bus.text_out, 128'd0);

    // random key/plaintext pairs encrypted by the model, decrypted by the DUT
    for (int n = 0; n < 100; n++) begin
      k = rand128();
      p = rand128();
      keyExpand(k);
      c = modelEncrypt(p);
      applyStimulus(1'b1, k, 1'b0, '0);
      waitKeyReady(cyc);
      applyStimulus(1'b0, '0, 1'b1, c);
      waitDone(cyc);
      checkOutput("rand_text", bus.text_out, p);
    end

    // simultaneous kld and ld in IDLE: expansion starts, ld dropped
    @(negedge clk);
    d0 = done_seen;
    applyStimulus(1'b1, KEY1, 1'b1, CT1);
    checkOutput("t5_busy",      128'(bus.busy),      128'd1);
    checkOutput("t5_key_ready", 128'(bus.key_ready), 128'd0);
    waitKeyReady(cyc);
    checkOutput("t5_kready_latency", 128'(cyc), 128'd10);
    repeat (12) @(negedge clk);
    checkOutput("t5_dones", 128'(done_seen), 128'(d0));

    // reset in the middle of decryption at cnt=5
    applyStimulus(1'b0, '0, 1'b1, CT1);
    repeat (4) @(negedge clk);
    d0  = done_seen;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t6_busy",      128'(bus.busy),      128'd0);
    checkOutput("t6_key_ready", 128'(bus.key_ready), 128'd0);
    checkOutput("t6_text_out",  bus.text_out,        128'd0);
    checkOutput("t6_done",      128'(bus.done),      128'd0);
    repeat (15) @(negedge clk);
    checkOutput("t6_dones", 128'(done_seen), 128'(d0));

    // fresh key load and block after the reset
    applyStimulus(1'b1, KEY1, 1'b0, '0);
    waitKeyReady(cyc);
    checkOutput("t6_kready_latency", 128'(cyc), 128'd10);
    applyStimulus(1'b0, '0, 1'b1, CT1);
    waitDone(cyc);
    checkOutput("t6_latency", 128'(cyc), 128'd10);
    checkOutput("t6_text",    bus.text_out, PT1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
